// File: rtl/cms_heap_dump_ctrl_pkg.sv
// Shared types and helpers for the CMS heap dump controller.
// KV words are packed {value,key} with the key in the low bits.
package cms_dump_pkg;

    localparam int KEY_W    = 32;
    localparam int VALUE_W  = 32;
    localparam int KV_WIDTH = KEY_W + VALUE_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_TERM     = 3'd3,
        ST_WAIT_OUT = 3'd4
    } state_t;

    // Closing beat of a dump that ended early (timeout or abort).
    localparam logic [KV_WIDTH-1:0] TERMINATOR = '0;

    function automatic logic [KV_WIDTH-1:0] kv_pack(input logic [VALUE_W-1:0] value,
                                                    input logic [KEY_W-1:0] key);
        return {value, key};
    endfunction

    function automatic logic [KEY_W-1:0] kv_key(input logic [KV_WIDTH-1:0] kv);
        return kv[KEY_W-1:0];
    endfunction

    function automatic logic [VALUE_W-1:0] kv_value(input logic [KV_WIDTH-1:0] kv);
        return kv[KV_WIDTH-1:KEY_W];
    endfunction

endpackage

// File: rtl/cms_heap_dump_ctrl_if.sv
// Bus bundle between the CMS kernel, the heap and the dump stream.
interface cms_heap_dump_ctrl_if #(
    parameter int KV_W = cms_dump_pkg::KV_WIDTH
);
    // Handshakes: cms_kv/heap_kv_in are strobes with no backpressure; a heap pop
    // happens on heap_kv_out_valid && heap_kv_out_ready; a dump beat transfers on
    // dump_TVALID && dump_TREADY, and TVALID/TDATA/TLAST hold until it does.
    logic [KV_W-1:0] cms_kv;
    logic            cms_kv_valid;
    logic [KV_W-1:0] heap_kv_in;
    logic            heap_kv_in_valid;
    logic [KV_W-1:0] heap_kv_out;
    logic            heap_kv_out_valid;
    logic            heap_kv_out_ready;
    logic [KV_W-1:0] dump_TDATA;
    logic            dump_TVALID;
    logic            dump_TREADY;
    logic            dump_TLAST;

    modport master (
        input  cms_kv, cms_kv_valid, heap_kv_out, heap_kv_out_valid, dump_TREADY,
        output heap_kv_in, heap_kv_in_valid, heap_kv_out_ready,
        output dump_TDATA, dump_TVALID, dump_TLAST
    );

    modport slave (
        output cms_kv, cms_kv_valid, heap_kv_out, heap_kv_out_valid, dump_TREADY,
        input  heap_kv_in, heap_kv_in_valid, heap_kv_out_ready,
        input  dump_TDATA, dump_TVALID, dump_TLAST
    );
endinterface

// File: rtl/cms_heap_dump_ctrl_axis_out_reg.sv
// Single-entry AXI-Stream holding register; a held beat is never retracted.
module axis_out_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         tready,
    output logic         tvalid,
    output logic [W-1:0] tdata,
    output logic         tlast,
    output logic         free
);
    // Free when empty or when the held beat leaves this cycle.
    assign free = !tvalid || tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tlast  <= load_last;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end
    end
endmodule

// File: rtl/cms_heap_dump_ctrl.sv
// Shares the CMS heap between the insert path and a top-K dump that streams
// popped entries out as one AXI-Stream packet terminated by TLAST.
module cms_heap_dump_ctrl
    import cms_dump_pkg::*;
#(
    parameter int KEY_WIDTH     = 32,
    parameter int VALUE_WIDTH   = 32,
    parameter int HEAP_DEPTH    = 256,
    parameter int CNT_WIDTH     = 9,
    parameter int SETTLE_CYCLES = 4,
    parameter int EMPTY_TIMEOUT = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] count,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 done_short,
    output logic                 done_aborted,
    output logic [CNT_WIDTH-1:0] popped_cnt,
    output logic [31:0]          dropped_cnt,
    output state_t               dbg_state,
    cms_heap_dump_ctrl_if.master bus
);
    localparam int KV_W  = KEY_WIDTH + VALUE_WIDTH;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W  = $clog2(EMPTY_TIMEOUT + 1);

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] remaining;
    logic [SET_W-1:0]     settle_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic                 short_flag, abort_flag;
    logic                 pop, out_load, out_last, out_free;
    logic                 start_ok, set_abort, set_short, finish;
    logic [KV_W-1:0]      out_data;

    axis_out_reg #(.W(KV_W)) u_out (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .load      (out_load),
        .load_data (out_data),
        .load_last (out_last),
        .tready    (bus.dump_TREADY),
        .tvalid    (bus.dump_TVALID),
        .tdata     (bus.dump_TDATA),
        .tlast     (bus.dump_TLAST),
        .free      (out_free)
    );

    assign bus.heap_kv_out_ready = pop;
    assign busy                  = (state != ST_IDLE);
    assign dbg_state             = state;

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        out_load  = 1'b0;
        out_data  = bus.heap_kv_out;
        out_last  = 1'b0;
        start_ok  = 1'b0;
        set_abort = 1'b0;
        set_short = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    start_ok = 1'b1;
                    state_n  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    set_abort = 1'b1;
                    state_n   = ST_TERM;
                end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Abort gates the pop in the same cycle it arrives.
                if (abort) begin
                    set_abort = 1'b1;
                    state_n   = ST_TERM;
                end else if (bus.heap_kv_out_valid && remaining != '0 && out_free) begin
                    pop      = 1'b1;
                    out_load = 1'b1;
                    out_last = (remaining == CNT_WIDTH'(1));
                    if (out_last) state_n = ST_WAIT_OUT;
                end else if (!bus.heap_kv_out_valid && out_free &&
                             to_cnt == TO_W'(EMPTY_TIMEOUT - 1)) begin
                    set_short = 1'b1;
                    state_n   = ST_TERM;
                end
            end
            ST_TERM: begin
                if (out_free) begin
                    out_load = 1'b1;
                    out_data = TERMINATOR;
                    out_last = 1'b1;
                    state_n  = ST_WAIT_OUT;
                end
            end
            ST_WAIT_OUT: begin
                if (bus.dump_TVALID && bus.dump_TREADY && bus.dump_TLAST) begin
                    finish  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            remaining        <= '0;
            popped_cnt       <= '0;
            settle_cnt       <= '0;
            to_cnt           <= '0;
            short_flag       <= 1'b0;
            abort_flag       <= 1'b0;
            done             <= 1'b0;
            done_short       <= 1'b0;
            done_aborted     <= 1'b0;
            dropped_cnt      <= '0;
            bus.heap_kv_in       <= '0;
            bus.heap_kv_in_valid <= 1'b0;
        end else begin
            bus.heap_kv_in       <= bus.cms_kv;
            bus.heap_kv_in_valid <= bus.cms_kv_valid && (state == ST_IDLE);
            if (bus.cms_kv_valid && state != ST_IDLE && dropped_cnt != '1)
                dropped_cnt <= dropped_cnt + 32'd1;

            done <= finish;
            if (finish) begin
                done_short   <= short_flag;
                done_aborted <= abort_flag;
            end

            if (start_ok) begin
                remaining  <= (count == '0) ? CNT_WIDTH'(HEAP_DEPTH) : count;
                popped_cnt <= '0;
                settle_cnt <= '0;
                short_flag <= 1'b0;
                abort_flag <= 1'b0;
            end
            if (state == ST_SETTLE) settle_cnt <= settle_cnt + SET_W'(1);
            if (pop) begin
                remaining  <= remaining - CNT_WIDTH'(1);
                popped_cnt <= popped_cnt + CNT_WIDTH'(1);
            end
            if (set_abort) abort_flag <= 1'b1;
            if (set_short) short_flag <= 1'b1;

            // Empty-heap timer: cleared by a valid heap, frozen while the output stalls.
            if (state != ST_DRAIN || bus.heap_kv_out_valid) to_cnt <= '0;
            else if (out_free) to_cnt <= to_cnt + TO_W'(1);
        end
    end
endmodule

// File: tb/tb_cms_heap_dump_ctrl.sv
// Directed bench for cms_heap_dump_ctrl with a queue-backed heap model and beat scoreboard.
module tb_cms_heap_dump_ctrl;
    import cms_dump_pkg::*;

    localparam int CW = 9;
    localparam int KW = KV_WIDTH;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] count = '0;
    logic          busy, done, done_short, done_aborted;
    logic [CW-1:0] popped_cnt;
    logic [31:0]   dropped_cnt;
    state_t        dbg_state;

    cms_heap_dump_ctrl_if bus ();

    cms_heap_dump_ctrl dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .start        (start),
        .count        (count),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .done_short   (done_short),
        .done_aborted (done_aborted),
        .popped_cnt   (popped_cnt),
        .dropped_cnt  (dropped_cnt),
        .dbg_state    (dbg_state),
        .bus          (bus)
    );

    always #5 ap_clk = ~ap_clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    int          done_cnt = 0;
    int          exp_drop = 0;
    int          bad_ins = 0;
    int          beat_cyc[$];
    logic [KW:0]   exp_q[$];
    logic [KW-1:0] heap_q[$];
    logic          pop_now = 1'b0;
    logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_busy = 1'b0;
    logic [KW-1:0] prev_data = '0;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [KW:0] obs, input logic [KW:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Heap model: pop decision sampled mid-cycle, applied at the edge.
    always @(negedge ap_clk) pop_now = bus.heap_kv_out_ready && bus.heap_kv_out_valid;
    always @(posedge ap_clk) begin
        cyc_n++;
        if (pop_now && heap_q.size() != 0) void'(heap_q.pop_front());
        #1;
        bus.heap_kv_out_valid = (heap_q.size() != 0);
        bus.heap_kv_out       = (heap_q.size() != 0) ? heap_q[0] : '0;
    end

    // Output monitor and scoreboard.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            prev_valid = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (bus.cms_kv_valid && busy) exp_drop++;
            if (bus.heap_kv_in_valid && prev_busy) bad_ins++;
            if (bus.heap_kv_out_ready)
                chk_b("pop_allowed", busy && bus.heap_kv_out_valid &&
                      (!bus.dump_TVALID || bus.dump_TREADY), 1'b1);
            if (prev_valid && !prev_ready) begin
                chk_b("hold_valid", bus.dump_TVALID, 1'b1);
                chk_d("hold_beat", {bus.dump_TLAST, bus.dump_TDATA}, {prev_last, prev_data});
            end
            if (bus.dump_TVALID && bus.dump_TREADY) begin
                beat_cyc.push_back(cyc_n);
                chk_b("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0)
                    chk_d("beat", {bus.dump_TLAST, bus.dump_TDATA}, exp_q.pop_front());
            end
            prev_valid = bus.dump_TVALID;
            prev_ready = bus.dump_TREADY;
            prev_last  = bus.dump_TLAST;
            prev_data  = bus.dump_TDATA;
            prev_busy  = busy;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic fill_heap(input int n, input int base);
        heap_q.delete();
        for (int i = 0; i < n; i++)
            heap_q.push_back(kv_pack(32'(base * 16 + i * 3 + 7), 32'(32'h1000 + base + i)));
    endtask

    task automatic expect_front(input int n, input logic last_on_n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1) && last_on_n, heap_q[i]});
    endtask

    task automatic pulse_start(input logic [CW-1:0] c);
        start = 1'b1;
        count = c;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input logic toggle);
        int base;
        int t;
        base = done_cnt;
        t = 0;
        while (done_cnt == base && t < budget) begin
            if (toggle) bus.dump_TREADY = ~bus.dump_TREADY;
            cyc(1);
            t++;
        end
        chk_i(tag, done_cnt - base, 1);
    endtask

    task automatic wait_tvalid(input string tag, input int budget);
        int t;
        t = 0;
        while (!bus.dump_TVALID && t < budget) begin
            cyc(1);
            t++;
        end
        chk_b(tag, bus.dump_TVALID, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            mark;
        int            dc;
        logic [KW-1:0] first;
        logic [KW-1:0] ins;

        bus.cms_kv            = '0;
        bus.cms_kv_valid      = 1'b0;
        bus.dump_TREADY       = 1'b1;
        bus.heap_kv_out       = '0;
        bus.heap_kv_out_valid = 1'b0;
        cyc(2);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_tvalid", bus.dump_TVALID, 1'b0);
        chk_b("rst_ins_valid", bus.heap_kv_in_valid, 1'b0);
        chk_b("rst_pop", bus.heap_kv_out_ready, 1'b0);
        chk_i("rst_popped", int'(popped_cnt), 0);
        chk_i("rst_dropped", int'(dropped_cnt), 0);
        ap_rst_n = 1'b1;
        cyc(2);

        // Plain insert, one-cycle latency.
        ins = kv_pack(32'hCAFE0001, 32'h0000BEEF);
        bus.cms_kv       = ins;
        bus.cms_kv_valid = 1'b1;
        cyc(1);
        bus.cms_kv_valid = 1'b0;
        chk_b("ins_valid", bus.heap_kv_in_valid, 1'b1);
        chk_d("ins_data", {1'b0, bus.heap_kv_in}, {1'b0, ins});
        cyc(1);
        chk_b("ins_valid_clear", bus.heap_kv_in_valid, 1'b0);

        // Start together with abort is ignored.
        start = 1'b1;
        abort = 1'b1;
        count = 9'd4;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        chk_b("start_abort_busy", busy, 1'b0);

        // Four of ten entries, TREADY high; a second start while busy is ignored.
        fill_heap(10, 0);
        expect_front(4, 1'b1);
        pulse_start(9'd4);
        chk_b("t1_busy", busy, 1'b1);
        start = 1'b1;
        count = 9'd1;
        cyc(1);
        start = 1'b0;
        wait_done("t1_done", 200, 1'b0);
        chk_i("t1_popped", int'(popped_cnt), 4);
        chk_b("t1_short", done_short, 1'b0);
        chk_b("t1_aborted", done_aborted, 1'b0);
        chk_i("t1_exp_left", exp_q.size(), 0);
        chk_i("t1_heap_left", heap_q.size(), 6);
        chk_b("t1_idle", busy, 1'b0);

        // Short heap: three beats, empty timeout, terminator.
        fill_heap(3, 100);
        expect_front(3, 1'b0);
        exp_q.push_back({1'b1, TERMINATOR});
        mark = beat_cyc.size();
        pulse_start(9'd8);
        wait_done("t2_done", 300, 1'b0);
        chk_b("t2_short", done_short, 1'b1);
        chk_b("t2_aborted", done_aborted, 1'b0);
        chk_i("t2_popped", int'(popped_cnt), 3);
        chk_i("t2_exp_left", exp_q.size(), 0);
        chk_i("t2_beats", beat_cyc.size() - mark, 4);
        chk_i("t2_gap", beat_cyc[mark + 3] - beat_cyc[mark + 2], 17);

        // Toggling TREADY: hold/pop gating checked by the monitor.
        fill_heap(6, 200);
        expect_front(5, 1'b1);
        mark = beat_cyc.size();
        pulse_start(9'd5);
        wait_done("t3_done", 300, 1'b1);
        bus.dump_TREADY = 1'b1;
        chk_i("t3_popped", int'(popped_cnt), 5);
        chk_i("t3_beats", beat_cyc.size() - mark, 5);
        chk_i("t3_heap_left", heap_q.size(), 1);
        chk_i("t3_exp_left", exp_q.size(), 0);

        // Inserts held high across a dump.
        fill_heap(2, 300);
        expect_front(2, 1'b1);
        ins = kv_pack(32'h00000055, 32'h00000077);
        bus.cms_kv       = ins;
        bus.cms_kv_valid = 1'b1;
        cyc(2);
        pulse_start(9'd2);
        wait_done("t4_done", 200, 1'b0);
        chk_b("t4_resume_valid", bus.heap_kv_in_valid, 1'b1);
        chk_d("t4_resume_data", {1'b0, bus.heap_kv_in}, {1'b0, ins});
        chk_i("t4_ins_while_busy", bad_ins, 0);
        chk_i("t4_dropped", int'(dropped_cnt), exp_drop);
        bus.cms_kv_valid = 1'b0;
        cyc(1);

        // Abort in DRAIN with a beat stuck behind TREADY=0.
        fill_heap(5, 400);
        first = heap_q[0];
        exp_q.push_back({1'b0, first});
        exp_q.push_back({1'b1, TERMINATOR});
        bus.dump_TREADY = 1'b0;
        pulse_start(9'd5);
        wait_tvalid("t5_tvalid", 50);
        cyc(1);
        chk_i("t5_one_pop", heap_q.size(), 4);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        cyc(3);
        chk_b("t5_held_valid", bus.dump_TVALID, 1'b1);
        chk_d("t5_held_beat", {bus.dump_TLAST, bus.dump_TDATA}, {1'b0, first});
        chk_b("t5_busy", busy, 1'b1);
        chk_i("t5_no_pop", heap_q.size(), 4);
        bus.dump_TREADY = 1'b1;
        wait_done("t5_done", 100, 1'b0);
        chk_b("t5_aborted", done_aborted, 1'b1);
        chk_b("t5_short", done_short, 1'b0);
        chk_i("t5_popped", int'(popped_cnt), 1);
        chk_i("t5_exp_left", exp_q.size(), 0);

        // Reset mid-DRAIN discards the held beat without a done pulse.
        fill_heap(6, 500);
        bus.dump_TREADY = 1'b0;
        pulse_start(9'd6);
        wait_tvalid("t6_tvalid", 50);
        dc = done_cnt;
        ap_rst_n = 1'b0;
        #1;
        chk_b("t6_busy", busy, 1'b0);
        chk_b("t6_tvalid", bus.dump_TVALID, 1'b0);
        chk_d("t6_beat", {bus.dump_TLAST, bus.dump_TDATA}, '0);
        chk_b("t6_pop", bus.heap_kv_out_ready, 1'b0);
        chk_b("t6_done", done, 1'b0);
        chk_b("t6_aborted", done_aborted, 1'b0);
        chk_i("t6_popped", int'(popped_cnt), 0);
        chk_i("t6_dropped", int'(dropped_cnt), 0);
        exp_drop = 0;
        cyc(2);
        ap_rst_n = 1'b1;
        bus.dump_TREADY = 1'b1;
        cyc(2);
        chk_i("t6_no_done", done_cnt, dc);
        chk_i("t6_heap_left", heap_q.size(), 5);
        expect_front(3, 1'b1);
        pulse_start(9'd3);
        wait_done("t6_done_after", 200, 1'b0);
        chk_i("t6_popped_after", int'(popped_cnt), 3);
        chk_b("t6_aborted_after", done_aborted, 1'b0);
        chk_i("t6_exp_left", exp_q.size(), 0);

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cms_heap_dump_ctrl.md
Name: cms_heap_dump_ctrl

Overview:
Controller that sequences a top-K readout ("dump") of the CMS heap and shares the heap between the CMS insert path and the dump path. In normal operation it forwards CMS {key,value} inserts into the heap. On a dump command it freezes inserts, lets in-flight heap updates settle, pops up to N entries through the heap read handshake, and streams them out as an AXI-Stream packet with TLAST. It sits between the CMS ikernel's to_heap/heap_out ports and cms_heap, inside the CMS top wrapper.

Parameters:
KEY_WIDTH, 32, key field width; KV word is {value,key}, key in the low bits
VALUE_WIDTH, 32, value field width
HEAP_DEPTH, 256, heap entries; the maximum dump length
CNT_WIDTH, 9, entry counter width, equal to clog2(HEAP_DEPTH+1)
SETTLE_CYCLES, 4, cycles between the insert freeze and the first pop
EMPTY_TIMEOUT, 16, consecutive heap_kv_valid-low cycles in DRAIN treated as heap empty

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle dump request
count  in  CNT_WIDTH  entries requested, sampled on an accepted start; 0 means HEAP_DEPTH
abort  in  1  single-cycle dump abort
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a dump completes
done_short  out  1  registered; the last dump ended on EMPTY_TIMEOUT
done_aborted  out  1  registered; the last dump ended on abort
popped_cnt  out  CNT_WIDTH  registered; entries popped in the last dump
dropped_cnt  out  32  saturating count of CMS inserts dropped while frozen
cms_kv  in  KEY_WIDTH+VALUE_WIDTH  insert from CMS
cms_kv_valid  in  1  insert strobe (ap_vld style, no ready)
heap_kv_in  out  KEY_WIDTH+VALUE_WIDTH  insert to heap
heap_kv_in_valid  out  1  insert strobe to heap
heap_kv_out  in  KEY_WIDTH+VALUE_WIDTH  heap bottom entry
heap_kv_out_valid  in  1  heap bottom entry valid
heap_kv_out_ready  out  1  pop the heap bottom entry
dump_TDATA  out  KEY_WIDTH+VALUE_WIDTH  dump stream data
dump_TVALID  out  1  dump stream valid
dump_TREADY  in  1  dump stream ready
dump_TLAST  out  1  last beat of the dump

Behaviour:
- Reset: state IDLE. All outputs are 0 and all counters are 0. Reset is legal mid-dump; it discards the held beat without a done pulse.
- Insert path: heap_kv_in and heap_kv_in_valid are registered from cms_kv, with 1-cycle latency.
  - heap_kv_in_valid = cms_kv_valid only while in IDLE.
  - An insert strobe that arrives in any other state is dropped and increments dropped_cnt, saturating at 0xFFFFFFFF.
- Dump output: a single output register.
  - A beat transfers when dump_TVALID && dump_TREADY.
  - TVALID and TDATA stay stable until the beat is accepted.
- States:
  - IDLE: start with abort=0 latches N=(count==0?HEAP_DEPTH:count), clears popped_cnt, goes to SETTLE. A start while busy is ignored. If start and abort arrive in the same cycle, abort wins and start is ignored.
  - SETTLE: counts SETTLE_CYCLES cycles, then goes to DRAIN.
  - DRAIN: heap_kv_out_ready = heap_kv_out_valid && remaining!=0 && (!dump_TVALID || dump_TREADY).
    - Each pop loads the output register, decrements remaining and increments popped_cnt.
    - TLAST=1 on the pop that takes remaining to 0; then go to WAIT_OUT.
    - heap_kv_out_valid low for EMPTY_TIMEOUT consecutive cycles while remaining!=0 → set the short flag and go to TERM.
  - TERM: once the output register is free, load the terminator beat (TDATA=0, TLAST=1), then go to WAIT_OUT.
  - WAIT_OUT: when the TLAST beat is accepted, pulse done, update done_short and done_aborted, go to IDLE.
- Abort in SETTLE or DRAIN:
  - heap_kv_out_ready drops in the same cycle, combinationally gated.
  - A pending output beat is held until it is accepted; it is never retracted.
  - Then emit the terminator beat as in TERM with done_aborted=1.
  - Abort in IDLE, TERM or WAIT_OUT is ignored.
- Timeout counter: resets on every cycle with heap_kv_out_valid high, and is frozen while the output register is stalled.
- heap_kv_out_ready is never asserted outside DRAIN.

Decomposition:
- Package cms_dump_pkg holds:
  - the state enum;
  - the KV_WIDTH localparam;
  - pack/unpack helpers for the {value,key} word;
  - the TERMINATOR constant.
- One natural sub-module, axis_out_reg: a single-entry AXI-Stream holding register with TDATA and TLAST.

Test Plan:
- Heap holding 10 entries, start with count=4, TREADY=1 → 4 beats in heap order; TLAST on beat 4; done pulse with popped_cnt=4, done_short=0.
- Heap holding 3 entries, count=8 → 3 beats, then 16 idle cycles, then one zero beat with TLAST; done_short=1, popped_cnt=3.
- count=5 with TREADY toggling 1010… → data is never retracted; no pop while the output register is full; exactly 5 beats.
- cms_kv_valid held high through a dump → 0 heap inserts while busy; dropped_cnt equals the strobes seen while busy; inserts resume 1 cycle after return to IDLE.
- Abort in DRAIN with a beat pending and TREADY=0 → the pending beat is held, then accepted; then a terminator beat with TLAST; done_aborted=1.
- ap_rst_n asserted mid-DRAIN → all outputs 0 immediately; no done pulse; next start behaves normally.
